adder_hold_reg: RTL and testbench
=================================

// Module: adder_hold_reg
// PURPOSE
//  Adder Hold Register (ADD): stage directly downstream of the ALU. Captures the active-low
//  ALU result and flags on clk_2, restores true polarity, applies the BCD decimal-adjust
//  correction for SBC/ADC in decimal mode, then holds the byte and drives it onto the SB
//  and ADL buses under per-cycle enables. Consumed by accumulator, flags and address logic.
// PARAMETERS
//  DEC_ENABLE  1      1 = decimal-adjust stage present; 0 = daa_n/dsa_n ignored, binary only
//  BUS_IDLE    8'hFF  value presented on sb_out/adl_out bits not driven (precharged bus)
// PORTS
//  clk_2         in   1  phase-2 clock; all state updates on rising edge
//  reset_n       in   1  asynchronous, active-low reset
//  load          in   1  capture ALU outputs this cycle
//  alu_result_n  in   8  ALU result, inverted polarity
//  alu_cout_n    in   1  ALU carry out, active low
//  overflow_n    in   1  ALU overflow, active low
//  half_carry    in   1  ALU carry bit3->4 (incl. decimal half carry), active high
//  daa_n         in   1  decimal add adjust request, active low
//  dsa_n         in   1  decimal subtract adjust request, active low
//  ack           in   1  consumer has taken the held value
//  add_sb_0_6    in   1  drive add[6:0] onto sb_out[6:0]
//  add_sb_7      in   1  drive add[7] onto sb_out[7]
//  add_adl       in   1  drive add[7:0] onto adl_out
//  add           out  8  held, true-polarity (adjusted) result
//  carry         out  1  latched carry (= ~alu_cout_n at capture)
//  overflow      out  1  latched overflow (= ~overflow_n at capture)
//  valid         out  1  add/carry/overflow final and consumable
//  overrun       out  1  sticky: load arrived while in ADJUST (load dropped)
//  sb_out        out  8  SB bus contribution
//  adl_out       out  8  ADL bus contribution
// BEHAVIOUR
//  Reset (async, reset_n=0): state=EMPTY, add=8'h00, carry=0, overflow=0, valid=0,
//   overrun=0; sb_out=adl_out=BUS_IDLE. Held until first clk_2 edge after release.
//  States: EMPTY, ADJUST, HELD. valid=1 only in HELD.
//  Capture on load (EMPTY or HELD): add<=~alu_result_n; carry<=~alu_cout_n;
//   overflow<=~overflow_n; latch adj_lo/adj_hi and mode (add/sub) for the ADJUST cycle.
//   Decimal if DEC_ENABLE && (!daa_n || !dsa_n) -> ADJUST; else -> HELD (latency 1 cycle).
//  daa_n and dsa_n both low: daa takes priority.
//  adj_lo/adj_hi: add mode: adj_lo=half_carry, adj_hi=~alu_cout_n;
//   sub mode: adj_lo=~half_carry, adj_hi=alu_cout_n.
//  ADJUST (exactly 1 cycle, then HELD; decimal latency 2 cycles):
//   nibble-wise, no carry between nibbles, each nibble mod 16:
//   add mode: nib += 6 if its adj bit; sub mode: nib += 10 (i.e. -6) if its adj bit.
//   carry/overflow unchanged by adjust.
//  load in ADJUST: ignored, overrun<=1 (sticky until reset).
//  HELD: ack && !load -> EMPTY (add retains value, valid=0). load (with or without ack)
//   -> recapture, load wins. Neither -> stay HELD.
//  ack in EMPTY or ADJUST: no effect.
//  Bus drive combinational, only in HELD; otherwise BUS_IDLE:
//   sb_out[6:0]=add_sb_0_6?add[6:0]:BUS_IDLE[6:0]; sb_out[7]=add_sb_7?add[7]:BUS_IDLE[7];
//   adl_out=add_adl?add:BUS_IDLE. Enables independent; all may be high together.
//  Reset asserted mid-ADJUST or mid-HELD: immediate return to reset values, pending
//   adjust discarded.
// STRUCTURE
//  Shared package: state encoding (EMPTY/ADJUST/HELD), BCD_ADD_CORR=4'h6,
//   BCD_SUB_CORR=4'hA, default BUS_IDLE.
//  One sub-module: bcd_nibble_adjust (4-bit in, adj, mode -> 4-bit out, combinational),
//   instantiated twice for low and high nibble.
// TESTING
//  Binary: load, alu_result_n=8'hFC, alu_cout_n=1 -> next edge add=8'h03, carry=0, valid=1.
//  DAA: load, daa_n=0, alu_result_n=~8'h0A, half_carry=1, alu_cout_n=1 -> valid after 2
//   edges, add=8'h10, carry=0.
//  DSA: load, dsa_n=0, alu_result_n=~8'h0F, half_carry=0, alu_cout_n=0 -> add=8'h09, carry=1.
//  Bus: HELD add=8'h05, add_sb_0_6=1, add_sb_7=0, add_adl=0 -> sb_out=8'h85, adl_out=8'hFF;
//   state EMPTY with enables high -> both 8'hFF.
//  Handshake: HELD, load+ack same edge with new 8'h42 -> valid stays 1, add=8'h42; ack only
//   -> valid=0; load during ADJUST -> dropped, overrun=1.
//  Reset mid-ADJUST: reset_n low between edges -> add=8'h00, valid=0, state EMPTY at once.

Source files
------------

// File: rtl/adder_hold_reg_pkg.sv
// Shared definitions for the adder hold register: state encoding, BCD
// correction constants and the default precharged-bus value.
package adder_hold_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ADJUST = 2'd1,
    ST_HELD   = 2'd2
  } add_state_e;

  localparam logic [3:0] BCD_ADD_CORR     = 4'h6;
  localparam logic [3:0] BCD_SUB_CORR     = 4'hA;
  localparam logic [7:0] BUS_IDLE_DEFAULT = 8'hFF;

  // Subtract correction is +10, i.e. -6 modulo 16.
  function automatic logic [3:0] bcd_corr(input logic sub_mode);
    return sub_mode ? BCD_SUB_CORR : BCD_ADD_CORR;
  endfunction

endpackage

// File: rtl/adder_hold_reg_if.sv
// Signal bundle between the ALU/control side (master) and the adder hold
// register (slave); clock and reset stay outside as plain ports.
interface adder_hold_reg_if;

  logic       load;
  logic [7:0] alu_result_n;
  logic       alu_cout_n;
  logic       overflow_n;
  logic       half_carry;
  logic       daa_n;
  logic       dsa_n;
  logic       ack;
  logic       add_sb_0_6;
  logic       add_sb_7;
  logic       add_adl;

  logic [7:0] add;
  logic       carry;
  logic       overflow;
  logic       valid;
  logic       overrun;
  logic [7:0] sb_out;
  logic [7:0] adl_out;

  modport master (
    output load, alu_result_n, alu_cout_n, overflow_n, half_carry,
           daa_n, dsa_n, ack, add_sb_0_6, add_sb_7, add_adl,
    input  add, carry, overflow, valid, overrun, sb_out, adl_out
  );

  modport slave (
    input  load, alu_result_n, alu_cout_n, overflow_n, half_carry,
           daa_n, dsa_n, ack, add_sb_0_6, add_sb_7, add_adl,
    output add, carry, overflow, valid, overrun, sb_out, adl_out
  );

endinterface

// File: rtl/adder_hold_reg_bcd_nibble_adjust.sv
// Combinational decimal-adjust of one nibble; the sum wraps modulo 16 and
// no carry leaves the nibble.
module bcd_nibble_adjust
  import adder_hold_reg_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       adj_i,
  input  logic       sub_mode_i,
  output logic [3:0] nib_o
);

  always_comb begin
    nib_o = nib_i;
    if (adj_i) begin
      nib_o = nib_i + bcd_corr(sub_mode_i);
    end
  end

endmodule

// File: rtl/adder_hold_reg.sv
// Adder hold register: captures the inverted ALU result, optionally applies a
// one-cycle BCD adjust, then holds the byte and drives it onto SB/ADL.
module adder_hold_reg
  import adder_hold_reg_pkg::*;
#(
  parameter bit         DEC_ENABLE = 1'b1,
  parameter logic [7:0] BUS_IDLE   = BUS_IDLE_DEFAULT
) (
  input  logic             clk_2,
  input  logic             reset_n,
  adder_hold_reg_if.slave  bus
);

  add_state_e state_q, state_d;
  logic [7:0] add_q, add_d;
  logic       carry_q, carry_d;
  logic       overflow_q, overflow_d;
  logic       overrun_q, overrun_d;
  logic       adj_lo_q, adj_lo_d;
  logic       adj_hi_q, adj_hi_d;
  logic       sub_mode_q, sub_mode_d;

  logic       decimal_req;
  logic       sub_req;
  logic [3:0] lo_adjusted;
  logic [3:0] hi_adjusted;
  logic       held;

  // daa_n wins over dsa_n, so subtract mode only when daa_n is inactive.
  assign decimal_req = DEC_ENABLE && (!bus.daa_n || !bus.dsa_n);
  assign sub_req     = bus.daa_n;

  bcd_nibble_adjust u_adj_lo (
    .nib_i      (add_q[3:0]),
    .adj_i      (adj_lo_q),
    .sub_mode_i (sub_mode_q),
    .nib_o      (lo_adjusted)
  );

  bcd_nibble_adjust u_adj_hi (
    .nib_i      (add_q[7:4]),
    .adj_i      (adj_hi_q),
    .sub_mode_i (sub_mode_q),
    .nib_o      (hi_adjusted)
  );

  always_comb begin
    state_d    = state_q;
    add_d      = add_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    overrun_d  = overrun_q;
    adj_lo_d   = adj_lo_q;
    adj_hi_d   = adj_hi_q;
    sub_mode_d = sub_mode_q;

    case (state_q)
      ST_EMPTY, ST_HELD: begin
        if (bus.load) begin
          add_d      = ~bus.alu_result_n;
          carry_d    = ~bus.alu_cout_n;
          overflow_d = ~bus.overflow_n;
          sub_mode_d = sub_req;
          adj_lo_d   = sub_req ? ~bus.half_carry : bus.half_carry;
          adj_hi_d   = sub_req ? bus.alu_cout_n : ~bus.alu_cout_n;
          state_d    = decimal_req ? ST_ADJUST : ST_HELD;
        end else if (state_q == ST_HELD && bus.ack) begin
          state_d = ST_EMPTY;
        end
      end
      ST_ADJUST: begin
        add_d   = {hi_adjusted, lo_adjusted};
        state_d = ST_HELD;
        if (bus.load) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      add_q      <= 8'h00;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      overrun_q  <= 1'b0;
      adj_lo_q   <= 1'b0;
      adj_hi_q   <= 1'b0;
      sub_mode_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      add_q      <= add_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      overrun_q  <= overrun_d;
      adj_lo_q   <= adj_lo_d;
      adj_hi_q   <= adj_hi_d;
      sub_mode_q <= sub_mode_d;
    end
  end

  assign held = (state_q == ST_HELD);

  assign bus.add      = add_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = overflow_q;
  assign bus.valid    = held;
  assign bus.overrun  = overrun_q;

  // Undriven bus bits float back to the precharged idle value.
  assign bus.sb_out  = {(held && bus.add_sb_7)   ? add_q[7]   : BUS_IDLE[7],
                        (held && bus.add_sb_0_6) ? add_q[6:0] : BUS_IDLE[6:0]};
  assign bus.adl_out = (held && bus.add_adl) ? add_q : BUS_IDLE;

endmodule

// File: tb/tb_adder_hold_reg.sv
// Self-checking bench for adder_hold_reg: directed scenarios followed by
// randomized traffic, all checked against a behavioural reference model.
module tb_adder_hold_reg;

  logic clk_2   = 1'b0;
  logic reset_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  adder_hold_reg_if bus_if ();

  adder_hold_reg #(
    .DEC_ENABLE (1'b1),
    .BUS_IDLE   (8'hFF)
  ) dut (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk_2 = ~clk_2;

  // Reference model: what the consumer should see, not how it is built.
  logic [7:0] m_add;
  logic [7:0] m_final;
  logic       m_carry;
  logic       m_ovf;
  logic       m_overrun;
  logic       m_valid;
  logic       m_pending;

  function automatic logic [7:0] bcd_fix(input logic [7:0] v, input logic is_add,
                                         input logic hc, input logic cout_n);
    int lo, hi, corr;
    logic lo_adj, hi_adj;
    lo_adj = is_add ? hc : !hc;
    hi_adj = is_add ? !cout_n : cout_n;
    corr   = is_add ? 6 : 10;
    lo = (int'(v[3:0]) + (lo_adj ? corr : 0)) % 16;
    hi = (int'(v[7:4]) + (hi_adj ? corr : 0)) % 16;
    return 8'(hi * 16 + lo);
  endfunction

  task automatic modelReset();
    m_add = 8'h00; m_final = 8'h00; m_carry = 1'b0; m_ovf = 1'b0;
    m_overrun = 1'b0; m_valid = 1'b0; m_pending = 1'b0;
  endtask

  task automatic modelClock();
    if (m_pending) begin
      if (bus_if.load) m_overrun = 1'b1;
      m_add     = m_final;
      m_pending = 1'b0;
      m_valid   = 1'b1;
    end else if (bus_if.load) begin
      m_add   = ~bus_if.alu_result_n;
      m_carry = ~bus_if.alu_cout_n;
      m_ovf   = ~bus_if.overflow_n;
      if (!bus_if.daa_n || !bus_if.dsa_n) begin
        m_final   = bcd_fix(~bus_if.alu_result_n, !bus_if.daa_n,
                            bus_if.half_carry, bus_if.alu_cout_n);
        m_pending = 1'b1;
        m_valid   = 1'b0;
      end else begin
        m_valid = 1'b1;
      end
    end else if (m_valid && bus_if.ack) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareAll(input string tag);
    logic [7:0] exp_sb, exp_adl;
    exp_sb  = 8'hFF;
    exp_adl = 8'hFF;
    if (m_valid) begin
      if (bus_if.add_sb_7)   exp_sb[7]   = m_add[7];
      if (bus_if.add_sb_0_6) exp_sb[6:0] = m_add[6:0];
      if (bus_if.add_adl)    exp_adl     = m_add;
    end
    checkOutput({tag, ".valid"},    32'(bus_if.valid),    32'(m_valid));
    checkOutput({tag, ".add"},      32'(bus_if.add),      32'(m_add));
    checkOutput({tag, ".carry"},    32'(bus_if.carry),    32'(m_carry));
    checkOutput({tag, ".overflow"}, 32'(bus_if.overflow), 32'(m_ovf));
    checkOutput({tag, ".overrun"},  32'(bus_if.overrun),  32'(m_overrun));
    checkOutput({tag, ".sb_out"},   32'(bus_if.sb_out),   32'(exp_sb));
    checkOutput({tag, ".adl_out"},  32'(bus_if.adl_out),  32'(exp_adl));
  endtask

  task automatic applyStimulus(input logic load, input logic [7:0] res_n,
                               input logic cout_n, input logic ovf_n, input logic hc,
                               input logic daa_n, input logic dsa_n, input logic ack,
                               input logic en_sb06, input logic en_sb7, input logic en_adl);
    bus_if.load         = load;
    bus_if.alu_result_n = res_n;
    bus_if.alu_cout_n   = cout_n;
    bus_if.overflow_n   = ovf_n;
    bus_if.half_carry   = hc;
    bus_if.daa_n        = daa_n;
    bus_if.dsa_n        = dsa_n;
    bus_if.ack          = ack;
    bus_if.add_sb_0_6   = en_sb06;
    bus_if.add_sb_7     = en_sb7;
    bus_if.add_adl      = en_adl;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step(input string tag);
    @(posedge clk_2);
    modelClock();
    #1;
    compareAll(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    applyStimulus(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    #12;
    checkOutput("reset.add",     32'(bus_if.add),     32'h00);
    checkOutput("reset.valid",   32'(bus_if.valid),   32'h0);
    checkOutput("reset.overrun", 32'(bus_if.overrun), 32'h0);
    checkOutput("reset.sb_out",  32'(bus_if.sb_out),  32'hFF);
    checkOutput("reset.adl_out", 32'(bus_if.adl_out), 32'hFF);
    reset_n = 1'b1;

    // Binary capture, one-cycle latency.
    applyStimulus(1'b1, 8'hFC, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("bin");
    checkOutput("bin.add_const",   32'(bus_if.add),   32'h03);
    checkOutput("bin.carry_const", 32'(bus_if.carry), 32'h0);
    checkOutput("bin.valid_const", 32'(bus_if.valid), 32'h1);
    applyStimulus(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("ack_only");
    checkOutput("ack_only.valid_const", 32'(bus_if.valid), 32'h0);

    // Decimal add adjust: low nibble corrected, high nibble untouched.
    applyStimulus(1'b1, ~8'h1A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("daa1");
    checkOutput("daa1.valid_const", 32'(bus_if.valid), 32'h0);
    idle();
    step("daa2");
    checkOutput("daa2.add_const",   32'(bus_if.add),   32'h10);
    checkOutput("daa2.valid_const", 32'(bus_if.valid), 32'h1);
    bus_if.ack = 1'b1;
    step("daa_ack");

    // Decimal subtract adjust.
    applyStimulus(1'b1, ~8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("dsa1");
    idle();
    step("dsa2");
    checkOutput("dsa2.add_const",   32'(bus_if.add),   32'h09);
    checkOutput("dsa2.carry_const", 32'(bus_if.carry), 32'h1);

    // Bus drive with partial enables, then empty with all enables high.
    applyStimulus(1'b1, ~8'h05, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("bus_load");
    bus_if.load = 1'b0; bus_if.add_sb_0_6 = 1'b1;
    #1;
    checkOutput("bus.sb_out",  32'(bus_if.sb_out),  32'h85);
    checkOutput("bus.adl_out", 32'(bus_if.adl_out), 32'hFF);
    applyStimulus(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step("bus_empty");
    checkOutput("bus_empty.sb_out",  32'(bus_if.sb_out),  32'hFF);
    checkOutput("bus_empty.adl_out", 32'(bus_if.adl_out), 32'hFF);

    // Load together with ack recaptures and stays valid.
    applyStimulus(1'b1, ~8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step("hs_first");
    applyStimulus(1'b1, ~8'h42, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step("hs_both");
    checkOutput("hs_both.valid_const", 32'(bus_if.valid), 32'h1);
    checkOutput("hs_both.add_const",   32'(bus_if.add),   32'h42);

    // Load arriving during ADJUST is dropped and flagged.
    applyStimulus(1'b1, ~8'h23, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ovr_load");
    applyStimulus(1'b1, ~8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ovr_drop");
    checkOutput("ovr_drop.overrun_const", 32'(bus_if.overrun), 32'h1);
    checkOutput("ovr_drop.add_const",     32'(bus_if.add),     32'h23);

    // Reset between edges while an adjust is pending.
    applyStimulus(1'b1, ~8'h99, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step("rst_adj");
    idle();
    #2;
    reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_mid.add_const",     32'(bus_if.add),     32'h00);
    checkOutput("rst_mid.valid_const",   32'(bus_if.valid),   32'h0);
    checkOutput("rst_mid.overrun_const", 32'(bus_if.overrun), 32'h0);
    compareAll("rst_mid");
    #1;
    reset_n = 1'b1;
    step("rst_after");

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic dec, use_sub;
      dec     = ($urandom_range(0, 9) < 3);
      use_sub = $urandom_range(0, 1) == 1;
      applyStimulus($urandom_range(0, 1) == 1, 8'($urandom()),
                    1'($urandom()), 1'($urandom()), 1'($urandom()),
                    !(dec && !use_sub), !(dec && (use_sub || ($urandom_range(0, 3) == 0))),
                    ($urandom_range(0, 9) < 4),
                    1'($urandom()), 1'($urandom()), 1'($urandom()));
      step("rand");
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
